if_id_skid_reg: RTL and testbench

Parametrised IF/ID pipeline stage register with a 2-entry skid buffer and a valid/ready handshake on both sides.
- Carries PC, instruction, exception code and delay-slot flag from fetch to decode.
- Supports an exception flush that redirects the held PC to a handler or EPC value.
- Replaces the single-entry enable/stall register. Sits between the fetch unit and the decode/hazard unit.

---
 rtl/if_id_skid_reg_pkg.sv | 23 ++
 rtl/if_id_skid_reg_if.sv | 35 +++
 rtl/if_id_skid_reg_perf_cnt.sv | 28 ++
 rtl/if_id_skid_reg.sv | 121 ++++++++++++
 tb/tb_if_id_skid_reg.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/if_id_skid_reg_pkg.sv
// Shared pipeline types and constants for the IF/ID boundary and later stage registers.
package pipe_pkg;

  typedef logic [4:0] exccode_t;

  localparam exccode_t    EXC_NONE  = '0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    exccode_t    exccode;
    logic        delay;
  } if_id_payload_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_t;

endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch-to-decode handshake bundle: master is the surrounding pipeline, slave is the stage register.
interface if_id_skid_reg_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned IW = 32,
    parameter int unsigned EW = 5
) ();

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_pc;
    logic [IW-1:0] in_instr;
    logic [EW-1:0] in_exccode;
    logic          in_delay;
    logic          flush;
    logic [AW-1:0] flush_pc;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_pc;
    logic [IW-1:0] out_instr;
    logic [EW-1:0] out_exccode;
    logic          out_delay;

    modport master (
        output in_valid, in_pc, in_instr, in_exccode, in_delay,
        output flush, flush_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_exccode, out_delay
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_exccode, in_delay,
        input  flush, flush_pc, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_exccode, out_delay
    );

endinterface

// File: rtl/if_id_skid_reg_perf_cnt.sv
// Stall/bubble event counters for the IF/ID stage; only built with IF_ID_SKID_PERF_EN.
module if_id_perf_cnt (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_stall,
    input  logic        i_bubble,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_bubble_cnt
);

    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Free-running wrap; flush deliberately does not clear these.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (i_stall)  r_stall_cnt  <= r_stall_cnt + 32'd1;
            if (i_bubble) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign o_stall_cnt  = r_stall_cnt;
    assign o_bubble_cnt = r_bubble_cnt;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID stage register with 2-entry skid buffer and valid/ready on both sides.
// Optional perf counters under IF_ID_SKID_PERF_EN.
module if_id_skid_reg
  import pipe_pkg::*;
#(
    parameter int unsigned   AW        = 32,
    parameter int unsigned   IW        = 32,
    parameter int unsigned   EW        = 5,
    parameter logic [AW-1:0] RESET_PC  = AW'(pipe_pkg::RESET_PC),
    parameter logic [IW-1:0] NOP_INSTR = IW'(pipe_pkg::NOP_INSTR)
) (
    input  logic        Clk,
    input  logic        Reset,
    if_id_skid_reg_if.slave bus
`ifdef IF_ID_SKID_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
        logic [EW-1:0] exccode;
        logic          delay;
    } payload_t;

    occ_t     r_state;
    payload_t r_head;
    payload_t r_skid;
    logic     r_in_ready;
    logic     r_out_valid;
    payload_t w_in;
    logic     w_acc;
    logic     w_deq;

    // An empty head keeps its PC so EPC capture still sees the last real address.
    function automatic payload_t bubble(input logic [AW-1:0] pc);
        bubble = {pc, NOP_INSTR, EW'(0), 1'b0};
    endfunction

    assign w_in  = {bus.in_pc, bus.in_instr, bus.in_exccode, bus.in_delay};
    assign w_acc = bus.in_valid & r_in_ready;
    assign w_deq = r_out_valid & bus.out_ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= OCC_EMPTY;
            r_head      <= bubble(RESET_PC);
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= OCC_EMPTY;
            r_head      <= bubble(bus.flush_pc);
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                OCC_EMPTY: begin
                    if (w_acc) begin
                        r_head      <= w_in;
                        r_out_valid <= 1'b1;
                        r_state     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (w_acc && w_deq) begin
                        r_head <= w_in;
                    end else if (w_deq) begin
                        r_head      <= bubble(r_head.pc);
                        r_out_valid <= 1'b0;
                        r_state     <= OCC_EMPTY;
                    end else if (w_acc) begin
                        r_skid     <= w_in;
                        r_in_ready <= 1'b0;
                        r_state    <= OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (w_deq) begin
                        r_head     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= OCC_ONE;
                    end
                end
                default: begin
                    r_state     <= OCC_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_head.pc;
    assign bus.out_instr   = r_head.instr;
    assign bus.out_exccode = r_head.exccode;
    assign bus.out_delay   = r_head.delay;

`ifdef IF_ID_SKID_PERF_EN
    logic w_stall;
    logic w_bubble;

    assign w_stall  = bus.in_valid & ~r_in_ready;
    assign w_bubble = ~r_out_valid & bus.out_ready;

    if_id_perf_cnt u_perf (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_stall      (w_stall),
        .i_bubble     (w_bubble),
        .o_stall_cnt  (perf_stall_cnt),
        .o_bubble_cnt (perf_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed scoreboard bench for if_id_skid_reg; build with IF_ID_SKID_PERF_EN to also cover counters.
module tb_if_id_skid_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        delay;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    always #5 Clk = ~Clk;

    if_id_skid_reg_if #(.AW(32), .IW(32), .EW(5)) bus ();

`ifdef IF_ID_SKID_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
`endif

    if_id_skid_reg #(
        .AW        (32),
        .IW        (32),
        .EW        (5),
        .RESET_PC  (32'h0000_3000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .bus             (bus.slave)
`ifdef IF_ID_SKID_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        instr_of = {16'hC0DE, pc[15:0]};
    endfunction

    task automatic put(input logic v, input logic [31:0] pc, input logic [4:0] exc, input logic d);
        bus.in_valid   = v;
        bus.in_pc      = pc;
        bus.in_instr   = instr_of(pc);
        bus.in_exccode = exc;
        bus.in_delay   = d;
    endtask

    // Scoreboard feed: payloads driven by the stimulus, queued when the edge accepts them.
    always @(posedge Clk) begin
        if (Reset || bus.flush)
            exp_q.delete();
        else if (bus.in_valid && bus.in_ready)
            exp_q.push_back({bus.in_pc, bus.in_instr, bus.in_exccode, bus.in_delay});
    end

    // Monitor: every dequeue must match the oldest outstanding accepted payload.
    always @(negedge Clk) begin
        if (!Reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL deq_unexpected: got pc %h expected no output", bus.out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("deq_pc",    bus.out_pc,            e.pc);
                chk("deq_instr", bus.out_instr,         e.instr);
                chk("deq_exc",   32'(bus.out_exccode),  32'(e.exc));
                chk("deq_delay", 32'(bus.out_delay),    32'(e.delay));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;
        bus.out_ready = 1'b0;
        put(1'b0, 32'h0, 5'd0, 1'b0);
        cyc();
        cyc();
        Reset = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
        chk("rst_out_pc",    bus.out_pc,           32'h0000_3000);
        chk("rst_out_instr", bus.out_instr,        32'h0);
        chk("rst_out_exc",   32'(bus.out_exccode), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),    32'd1);

        // Back-to-back stream with decode always ready
        bus.out_ready = 1'b1;
        put(1'b1, 32'h3000, 5'd0, 1'b0); cyc();
        chk("strm0_valid", 32'(bus.out_valid), 32'd1);
        chk("strm0_pc",    bus.out_pc,         32'h3000);
        put(1'b1, 32'h3004, 5'd0, 1'b0); cyc();
        chk("strm1_pc",    bus.out_pc,         32'h3004);
        chk("strm1_ready", 32'(bus.in_ready),  32'd1);
        put(1'b1, 32'h3008, 5'd0, 1'b0); cyc();
        chk("strm2_pc",    bus.out_pc,         32'h3008);
        chk("strm2_ready", 32'(bus.in_ready),  32'd1);
        put(1'b0, 32'h0, 5'd0, 1'b0); cyc();
        chk("strm_end_valid", 32'(bus.out_valid), 32'd0);
        chk("strm_end_pc",    bus.out_pc,         32'h3008);
        chk("strm_end_instr", bus.out_instr,      32'h0);

        // Stall into FULL, then drain
        bus.out_ready = 1'b0;
        put(1'b1, 32'h3000, 5'd0, 1'b0); cyc();
        chk("stall_one_ready", 32'(bus.in_ready), 32'd1);
        put(1'b1, 32'h3004, 5'd0, 1'b0); cyc();
        chk("stall_full_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_full_pc",    bus.out_pc,        32'h3000);
        put(1'b1, 32'h3008, 5'd0, 1'b0); cyc();
        chk("stall_hold_pc",    bus.out_pc,        32'h3000);
        chk("stall_hold_instr", bus.out_instr,     instr_of(32'h3000));
        chk("stall_hold_ready", 32'(bus.in_ready), 32'd0);
        put(1'b0, 32'h0, 5'd0, 1'b0);
        bus.out_ready = 1'b1; cyc();
        chk("drain_pc",    bus.out_pc,         32'h3004);
        chk("drain_ready", 32'(bus.in_ready),  32'd1);
        cyc();
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Flush while FULL with a competing in_valid
        bus.out_ready = 1'b0;
        put(1'b1, 32'h3100, 5'd0, 1'b0); cyc();
        put(1'b1, 32'h3104, 5'd0, 1'b0); cyc();
        chk("pre_flush_ready", 32'(bus.in_ready), 32'd0);
        put(1'b1, 32'h3108, 5'd0, 1'b0);
        bus.flush = 1'b1; bus.flush_pc = 32'h4180; cyc();
        bus.flush = 1'b0;
        put(1'b0, 32'h0, 5'd0, 1'b0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_pc",    bus.out_pc,         32'h4180);
        chk("flush_instr", bus.out_instr,      32'h0);
        chk("flush_ready", 32'(bus.in_ready),  32'd1);
        cyc();
        chk("flush_drop",  32'(bus.out_valid), 32'd0);

        // Exception code and delay-slot flag carried, then cleared on empty
        put(1'b1, 32'h3200, 5'd4, 1'b1); cyc();
        put(1'b0, 32'h0, 5'd0, 1'b0);
        chk("exc_pc",    bus.out_pc,            32'h3200);
        chk("exc_code",  32'(bus.out_exccode),  32'd4);
        chk("exc_delay", 32'(bus.out_delay),    32'd1);
        bus.out_ready = 1'b1; cyc();
        chk("exc_clr_code",  32'(bus.out_exccode), 32'd0);
        chk("exc_clr_delay", 32'(bus.out_delay),   32'd0);
        chk("exc_clr_pc",    bus.out_pc,           32'h3200);

        // Reset wins over flush and acceptance in the same cycle
        put(1'b1, 32'h3300, 5'd0, 1'b0);
        bus.flush = 1'b1; bus.flush_pc = 32'h4180;
        Reset = 1'b1; cyc();
        Reset = 1'b0; bus.flush = 1'b0;
        put(1'b0, 32'h0, 5'd0, 1'b0);
        chk("rst2_pc",    bus.out_pc,         32'h3000);
        chk("rst2_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_ready", 32'(bus.in_ready),  32'd1);
`ifdef IF_ID_SKID_PERF_EN
        chk("rst2_stall_cnt",  perf_stall_cnt,  32'd0);
        chk("rst2_bubble_cnt", perf_bubble_cnt, 32'd0);
`endif
        cyc();
        chk("rst2_idle", 32'(bus.out_valid), 32'd0);
        chk("sb_empty",  32'(exp_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
